// File: rtl/winner_update_ctrl.sv
// winner_update_ctrl: takes a one-hot winner record from the 6-input comparator,
// strobes the winner update, optionally walks the losers with decay strobes,
// then waits out a refractory period before taking the next record.
// Optional feature macro: LOSER_DECAY_EN (adds the DECAY walk over the losers).
module winner_update_ctrl #(
    parameter int P_WIDTH   = 19,
    parameter int P_REFRACT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [5:0]         i_index,
    input  logic [P_WIDTH-1:0] i_result,
    input  logic               i_err_clr,
    output logic               o_ready,
    output logic [5:0]         o_upd_en,
    output logic [P_WIDTH-1:0] o_upd_value,
    output logic [2:0]         o_win_bin,
    output logic [5:0]         o_dec_en,
    output logic               o_nowin,
    output logic               o_err
);

    typedef enum logic [1:0] {IDLE, UPDATE, DECAY, REFRACT} state_t;

    // Last refractory count value; unused when the period is zero.
    localparam logic [3:0] REF_LAST = (P_REFRACT == 0) ? 4'd0 : 4'(P_REFRACT - 1);
    // Where UPDATE/DECAY hand over once the strobes are done.
    localparam state_t POST_STATE = (P_REFRACT == 0) ? IDLE : REFRACT;

    state_t             state_q, state_d;
    logic [3:0]         ref_cnt_q, ref_cnt_d;
    logic [5:0]         upd_en_q, upd_en_d;
    logic [P_WIDTH-1:0] upd_val_q, upd_val_d;
    logic [2:0]         win_bin_q, win_bin_d;
    logic               nowin_q, nowin_d;
    logic               err_q, err_d;
    logic               multi_hot;

    function automatic logic [2:0] onehot2bin(input logic [5:0] oh);
        logic [2:0] b;
        b = 3'd0;
        for (int i = 0; i < 6; i++)
            if (oh[i]) b = 3'(i);
        return b;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot = |(i_index & (i_index - 6'd1));

`ifdef LOSER_DECAY_EN
    logic [2:0] step_q, step_d, step_nxt;
    logic [5:0] dec_en_q, dec_en_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        upd_en_d  = '0;
        upd_val_d = upd_val_q;
        win_bin_d = win_bin_q;
        nowin_d   = 1'b0;
        err_d     = err_q & ~i_err_clr;
`ifdef LOSER_DECAY_EN
        step_d    = step_q;
        step_nxt  = step_q + 3'd1;
        if (step_nxt == win_bin_q) step_nxt = step_nxt + 3'd1;
`endif
        case (state_q)
            IDLE: begin
                ref_cnt_d = '0;
`ifdef LOSER_DECAY_EN
                step_d    = '0;
`endif
                if (i_valid) begin
                    if (i_index == 6'd0) begin
                        nowin_d = 1'b1;
                    end else if (multi_hot) begin
                        err_d = 1'b1;           // set beats a concurrent clear
                    end else begin
                        state_d   = UPDATE;
                        upd_en_d  = i_index;
                        upd_val_d = i_result;
                        win_bin_d = onehot2bin(i_index);
                    end
                end
            end
            UPDATE: begin
`ifdef LOSER_DECAY_EN
                state_d = DECAY;
                step_d  = (win_bin_q == 3'd0) ? 3'd1 : 3'd0;
`else
                state_d = POST_STATE;
`endif
                ref_cnt_d = '0;
            end
`ifdef LOSER_DECAY_EN
            DECAY: begin
                // Step past the winner; running off the end means all 5 losers were hit.
                if (step_nxt > 3'd5) begin
                    state_d = POST_STATE;
                    step_d  = '0;
                end else begin
                    step_d = step_nxt;
                end
            end
`endif
            REFRACT: begin
                if (ref_cnt_q == REF_LAST) begin
                    state_d   = IDLE;
                    ref_cnt_d = '0;
                end else begin
                    ref_cnt_d = ref_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef LOSER_DECAY_EN
        dec_en_d = (state_d == DECAY) ? (6'd1 << step_d) : 6'd0;
`endif
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ref_cnt_q <= '0;
            upd_en_q  <= '0;
            upd_val_q <= '0;
            win_bin_q <= '0;
            nowin_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            upd_en_q  <= upd_en_d;
            upd_val_q <= upd_val_d;
            win_bin_q <= win_bin_d;
            nowin_q   <= nowin_d;
            err_q     <= err_d;
        end
    end

`ifdef LOSER_DECAY_EN
    // Decay step counter and loser strobe register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q   <= '0;
            dec_en_q <= '0;
        end else begin
            step_q   <= step_d;
            dec_en_q <= dec_en_d;
        end
    end
    assign o_dec_en = dec_en_q;
`else
    assign o_dec_en = 6'd0;
`endif

    assign o_ready     = (state_q == IDLE);
    assign o_upd_en    = upd_en_q;
    assign o_upd_value = upd_val_q;
    assign o_win_bin   = win_bin_q;
    assign o_nowin     = nowin_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_winner_update_ctrl.sv
// Directed bench for winner_update_ctrl; expectations follow LOSER_DECAY_EN.
module tb_winner_update_ctrl;

    localparam int W = 19;
`ifdef LOSER_DECAY_EN
    localparam bit DECAY_ON = 1'b1;
    localparam int READY_AT = 11;
`else
    localparam bit DECAY_ON = 1'b0;
    localparam int READY_AT = 6;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [5:0]   i_index;
    logic [W-1:0] i_result;
    logic         i_err_clr;
    logic         o_ready;
    logic [5:0]   o_upd_en;
    logic [W-1:0] o_upd_value;
    logic [2:0]   o_win_bin;
    logic [5:0]   o_dec_en;
    logic         o_nowin;
    logic         o_err;

    int vecs = 0;
    int errs = 0;

    winner_update_ctrl #(.P_WIDTH(W), .P_REFRACT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_index(i_index),
        .i_result(i_result), .i_err_clr(i_err_clr), .o_ready(o_ready),
        .o_upd_en(o_upd_en), .o_upd_value(o_upd_value), .o_win_bin(o_win_bin),
        .o_dec_en(o_dec_en), .o_nowin(o_nowin), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_index = '0; i_result = '0; i_err_clr = 1'b0;
        tick(); tick();
        vecs++;
        if ({o_upd_en, o_upd_value, o_win_bin, o_dec_en, o_nowin, o_err} !== '0) begin
            errs++; $display("FAIL reset_outs: got %h want 0",
                {o_upd_en, o_upd_value, o_win_bin, o_dec_en, o_nowin, o_err});
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    // Winner at position 2; i_valid is held with another index while busy and must be ignored.
    task automatic test_update();
        logic [5:0] exp_d [0:4] = '{6'b000001, 6'b000010, 6'b001000, 6'b010000, 6'b100000};
        logic [5:0] exp;
        int k;
        i_valid = 1'b1; i_index = 6'b000100; i_result = 19'h00ABC;
        tick();
        i_index = 6'b001000; i_result = 19'h12345;
        vecs++;
        if (o_upd_en !== 6'b000100 || o_upd_value !== 19'h00ABC) begin
            errs++; $display("FAIL upd_strobe: got %b/%h want 000100/00abc", o_upd_en, o_upd_value);
        end
        vecs++;
        if (o_win_bin !== 3'd2 || o_ready !== 1'b0 || o_dec_en !== 6'd0) begin
            errs++; $display("FAIL upd_side: got bin=%0d rdy=%b dec=%b want 2/0/000000",
                o_win_bin, o_ready, o_dec_en);
        end
        k = 1;
        while (!o_ready && k < 30) begin
            tick();
            k++;
            exp = (DECAY_ON && k >= 2 && k <= 6) ? exp_d[k-2] : 6'd0;
            vecs++;
            if (o_dec_en !== exp || o_upd_en !== 6'd0 || o_win_bin !== 3'd2) begin
                errs++; $display("FAIL upd_walk T+%0d: got dec=%b upd=%b bin=%0d want dec=%b upd=0 bin=2",
                    k, o_dec_en, o_upd_en, o_win_bin, exp);
            end
        end
        i_valid = 1'b0;
        vecs++;
        if (k !== READY_AT) begin errs++; $display("FAIL upd_ready_at: got T+%0d want T+%0d", k, READY_AT); end
    endtask

    task automatic test_nowin();
        i_valid = 1'b1; i_index = 6'b000000; i_result = 19'h7;
        tick();
        i_valid = 1'b0;
        vecs++;
        if (o_nowin !== 1'b1 || o_upd_en !== 6'd0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL nowin_pulse: got nowin=%b upd=%b rdy=%b want 1/0/1", o_nowin, o_upd_en, o_ready);
        end
        tick();
        vecs++;
        if (o_nowin !== 1'b0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL nowin_end: got nowin=%b rdy=%b want 0/1", o_nowin, o_ready);
        end
    endtask

    task automatic test_err();
        i_valid = 1'b1; i_index = 6'b010010; i_result = 19'h55;
        tick();
        i_valid = 1'b0;
        vecs++;
        if (o_err !== 1'b1 || o_upd_en !== 6'd0 || o_dec_en !== 6'd0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL err_set: got err=%b upd=%b dec=%b rdy=%b want 1/0/0/1",
                o_err, o_upd_en, o_dec_en, o_ready);
        end
        tick(); tick();
        vecs++;
        if (o_err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b want 1", o_err); end
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        vecs++;
        if (o_err !== 1'b0) begin errs++; $display("FAIL err_clr: got %b want 0", o_err); end
        i_err_clr = 1'b1; i_valid = 1'b1; i_index = 6'b110000;
        tick();
        i_err_clr = 1'b0; i_valid = 1'b0;
        vecs++;
        if (o_err !== 1'b1) begin errs++; $display("FAIL err_set_wins: got %b want 1", o_err); end
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        vecs++;
        if (o_err !== 1'b0) begin errs++; $display("FAIL err_clr2: got %b want 0", o_err); end
    endtask

    task automatic test_pos5();
        logic [5:0] exp;
        int k;
        i_valid = 1'b1; i_index = 6'b100000; i_result = 19'h7FFFF;
        tick();
        i_valid = 1'b0;
        vecs++;
        if (o_win_bin !== 3'd5 || o_upd_en !== 6'b100000 || o_upd_value !== 19'h7FFFF) begin
            errs++; $display("FAIL pos5_upd: got bin=%0d upd=%b val=%h want 5/100000/7ffff",
                o_win_bin, o_upd_en, o_upd_value);
        end
        k = 1;
        while (!o_ready && k < 30) begin
            tick();
            k++;
            exp = (DECAY_ON && k >= 2 && k <= 6) ? (6'd1 << (k - 2)) : 6'd0;
            vecs++;
            if (o_dec_en !== exp) begin
                errs++; $display("FAIL pos5_dec T+%0d: got %b want %b", k, o_dec_en, exp);
            end
        end
        vecs++;
        if (k !== READY_AT) begin errs++; $display("FAIL pos5_ready_at: got T+%0d want T+%0d", k, READY_AT); end
    endtask

    // Reset lands in the third DECAY cycle (REFRACT when decay is compiled out).
    task automatic test_reset_mid();
        i_valid = 1'b1; i_index = 6'b000001; i_result = 19'h00123;
        tick();
        i_valid = 1'b0;
        tick(); tick(); tick();
        vecs++;
        if (o_dec_en !== (DECAY_ON ? 6'b001000 : 6'd0)) begin
            errs++; $display("FAIL mid_pre: got %b want %b", o_dec_en, DECAY_ON ? 6'b001000 : 6'd0);
        end
        #1 rst_n = 1'b0;
        #1;
        vecs++;
        if ({o_upd_en, o_upd_value, o_win_bin, o_dec_en, o_nowin, o_err} !== '0 || o_ready !== 1'b1) begin
            errs++; $display("FAIL mid_async: got outs=%h rdy=%b want 0/1",
                {o_upd_en, o_upd_value, o_win_bin, o_dec_en, o_nowin, o_err}, o_ready);
        end
        #1 rst_n = 1'b1;
        i_valid = 1'b1; i_index = 6'b000010; i_result = 19'h00456;
        tick();
        i_valid = 1'b0;
        vecs++;
        if (o_upd_en !== 6'b000010 || o_upd_value !== 19'h00456 || o_win_bin !== 3'd1) begin
            errs++; $display("FAIL mid_accept: got upd=%b val=%h bin=%0d want 000010/00456/1",
                o_upd_en, o_upd_value, o_win_bin);
        end
    endtask

    initial begin
        test_reset();
        test_update();
        test_nowin();
        test_err();
        test_pos5();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
